// File: rtl/conv2d_param_engine.sv
// Parametrised valid-padding, stride-1 conv layer: RAM-resident maps, one signed 8x8 MAC per cycle.
// Define CONV_RELU_EN to clamp negative requantised results to zero before they are stored.
module conv2d_param_engine #(
  parameter int IN_H  = 32'sd13,
  parameter int IN_W  = 32'sd13,
  parameter int IN_C  = 32'sd32,
  parameter int OUT_C = 32'sd64,
  parameter int K     = 32'sd3,
  parameter int ACC_W = 32'sd32,
  parameter int SHIFT = 32'sd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load_en,
  input  logic [1:0]  load_sel,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic [31:0] read_addr,
  output logic [7:0]  read_data,
  output logic        busy,
  output logic        done
);
  localparam int OUT_H     = IN_H - K + 32'sd1;
  localparam int OUT_W     = IN_W - K + 32'sd1;
  localparam int IN_DEPTH  = IN_H * IN_W * IN_C;
  localparam int W_DEPTH   = OUT_C * K * K * IN_C;
  localparam int OUT_DEPTH = OUT_H * OUT_W * OUT_C;
  localparam int IAW = (IN_DEPTH > 32'sd1) ? $clog2(IN_DEPTH) : 32'sd1;
  localparam int WAW = (W_DEPTH > 32'sd1) ? $clog2(W_DEPTH) : 32'sd1;
  localparam int OAW = (OUT_DEPTH > 32'sd1) ? $clog2(OUT_DEPTH) : 32'sd1;
  localparam int BAW = (OUT_C > 32'sd1) ? $clog2(OUT_C) : 32'sd1;
  localparam int CW  = 32'sd16;
  localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE   = CW'(32'sd1);
  localparam logic [CW-1:0] K_LAST  = CW'(K - 32'sd1);
  localparam logic [CW-1:0] IC_LAST = CW'(IN_C - 32'sd1);
  localparam logic [CW-1:0] OC_LAST = CW'(OUT_C - 32'sd1);
  localparam logic [CW-1:0] OX_LAST = CW'(OUT_W - 32'sd1);
  localparam logic [CW-1:0] OY_LAST = CW'(OUT_H - 32'sd1);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(32'sd127);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-32'sd128);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_BIAS = 3'd1, S_MAC = 3'd2, S_DRAIN = 3'd3,
    S_WRITE = 3'd4, S_FIN = 3'd5, S_DONE = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] oy_q, oy_d, ox_q, ox_d, oc_q, oc_d;
  logic [CW-1:0] ky_q, ky_d, kx_q, kx_d, ic_q, ic_d;
  logic drain_q, drain_d;
  logic busy_q, done_q, v1_q, v2_q;
  logic [7:0] rdata_q, q_s;
  logic signed [7:0] in_rd_q, w_rd_q;
  logic signed [15:0] prod_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, shifted_s;
  logic [IAW-1:0] in_addr_s;
  logic [WAW-1:0] w_addr_s;
  logic [OAW-1:0] out_addr_s;
  logic idle_s, load_ok_s, write_s;

  logic signed [7:0]  in_mem   [IN_DEPTH];
  logic signed [7:0]  w_mem    [W_DEPTH];
  logic signed [31:0] bias_mem [OUT_C];
  logic [7:0]         out_mem  [OUT_DEPTH];

  assign idle_s    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign load_ok_s = load_en && idle_s && !reset;
  assign write_s   = (state_q == S_WRITE) && !reset;
  assign busy      = busy_q;
  assign done      = done_q;
  assign read_data = rdata_q;

  // Operand/result addressing from the loop counters, and floor-shift plus int8 saturation.
  always_comb begin
    in_addr_s  = IAW'(((32'(oy_q) + 32'(ky_q)) * 32'(IN_W) + 32'(ox_q) + 32'(kx_q)) * 32'(IN_C) + 32'(ic_q));
    w_addr_s   = WAW'(((32'(oc_q) * 32'(K) + 32'(ky_q)) * 32'(K) + 32'(kx_q)) * 32'(IN_C) + 32'(ic_q));
    out_addr_s = OAW'((32'(oy_q) * 32'(OUT_W) + 32'(ox_q)) * 32'(OUT_C) + 32'(oc_q));
    shifted_s  = acc_q >>> SHIFT;
`ifdef CONV_RELU_EN
    if (shifted_s[ACC_W-1]) q_s = 8'h00;
    else if (shifted_s > Q_MAX) q_s = 8'h7F;
    else q_s = shifted_s[7:0];
`else
    if (shifted_s > Q_MAX) q_s = 8'h7F;
    else if (shifted_s < Q_MIN) q_s = 8'h80;
    else q_s = shifted_s[7:0];
`endif
  end

  // Sequencer: per output BIAS, K*K*IN_C MAC issues, two drain cycles for the read/multiply pipe, WRITE.
  always_comb begin
    state_d = state_q;
    oy_d = oy_q; ox_d = ox_q; oc_d = oc_q;
    ky_d = ky_q; kx_d = kx_q; ic_d = ic_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_BIAS;
          oy_d = C_ZERO; ox_d = C_ZERO; oc_d = C_ZERO;
        end else begin
          state_d = state_q;
        end
      end
      S_BIAS: begin
        state_d = S_MAC;
        ky_d = C_ZERO; kx_d = C_ZERO; ic_d = C_ZERO;
      end
      S_MAC: begin
        if (ic_q == IC_LAST) begin
          ic_d = C_ZERO;
          if (kx_q == K_LAST) begin
            kx_d = C_ZERO;
            if (ky_q == K_LAST) begin
              ky_d = C_ZERO; drain_d = 1'b0; state_d = S_DRAIN;
            end else begin
              ky_d = ky_q + C_ONE;
            end
          end else begin
            kx_d = kx_q + C_ONE;
          end
        end else begin
          ic_d = ic_q + C_ONE;
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          drain_d = 1'b0; state_d = S_WRITE;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_BIAS;
        if (oc_q == OC_LAST) begin
          oc_d = C_ZERO;
          if (ox_q == OX_LAST) begin
            ox_d = C_ZERO;
            if (oy_q == OY_LAST) begin
              oy_d = C_ZERO; state_d = S_FIN;
            end else begin
              oy_d = oy_q + C_ONE;
            end
          end else begin
            ox_d = ox_q + C_ONE;
          end
        end else begin
          oc_d = oc_q + C_ONE;
        end
      end
      S_FIN:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_BIAS) acc_d = ACC_W'(bias_mem[oc_q[BAW-1:0]]);
    else if (v2_q) acc_d = acc_q + ACC_W'(prod_q);
    else acc_d = acc_q;
  end

  // Control, MAC pipeline and status registers; reset abandons any run in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      oy_q <= C_ZERO; ox_q <= C_ZERO; oc_q <= C_ZERO;
      ky_q <= C_ZERO; kx_q <= C_ZERO; ic_q <= C_ZERO;
      drain_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
      v1_q <= 1'b0; v2_q <= 1'b0;
      in_rd_q <= 8'sd0; w_rd_q <= 8'sd0; prod_q <= 16'sd0;
      acc_q <= {ACC_W{1'b0}};
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      oy_q <= oy_d; ox_q <= ox_d; oc_q <= oc_d;
      ky_q <= ky_d; kx_q <= kx_d; ic_q <= ic_d;
      drain_q <= drain_d;
      busy_q <= !idle_s;
      done_q <= (state_q == S_DONE);
      v1_q <= (state_q == S_MAC);
      v2_q <= v1_q;
      in_rd_q <= in_mem[in_addr_s];
      w_rd_q <= w_mem[w_addr_s];
      prod_q <= 16'(in_rd_q) * 16'(w_rd_q);
      acc_q <= acc_d;
      rdata_q <= (read_addr < 32'(OUT_DEPTH)) ? out_mem[read_addr[OAW-1:0]] : 8'h00;
    end
  end

  // Host loads and result write-back; RAM contents are deliberately kept across reset.
  always_ff @(posedge clk) begin
    if (load_ok_s && (load_sel == 2'd0) && (load_addr < 32'(IN_DEPTH)))
      in_mem[load_addr[IAW-1:0]] <= load_data[7:0];
    if (load_ok_s && (load_sel == 2'd1) && (load_addr < 32'(W_DEPTH)))
      w_mem[load_addr[WAW-1:0]] <= load_data[7:0];
    if (load_ok_s && (load_sel == 2'd2) && (load_addr < 32'(OUT_C)))
      bias_mem[load_addr[BAW-1:0]] <= load_data;
    if (write_s)
      out_mem[out_addr_s] <= q_s;
  end
endmodule

// File: tb/tb_conv2d_param_engine.sv
// Directed bench for conv2d_param_engine (4x4x2 in, 2 filters, 3x3), SHIFT=0 and SHIFT=1 instances.
module tb_conv2d_param_engine;
  localparam int IH = 4, IW = 4, IC = 2, OC = 2, KK = 3;
  localparam int OW = 2, NOUT = 8, IN_D = 32, W_D = 36, LAT = 178;
`ifdef CONV_RELU_EN
  localparam logic [7:0] SAT_NEG = 8'h00;
  localparam logic [7:0] MINUS1  = 8'h00;
`else
  localparam logic [7:0] SAT_NEG = 8'h80;
  localparam logic [7:0] MINUS1  = 8'hFF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, load_en;
  logic [1:0] load_sel;
  logic [31:0] load_addr, load_data, read_addr;
  logic [7:0] rd0, rd1;
  logic busy0, busy1, done0, done1;
  int checks = 0, failures = 0;

  conv2d_param_engine #(.IN_H(IH), .IN_W(IW), .IN_C(IC), .OUT_C(OC), .K(KK), .ACC_W(32), .SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .read_addr(read_addr),
    .read_data(rd0), .busy(busy0), .done(done0));
  conv2d_param_engine #(.IN_H(IH), .IN_W(IW), .IN_C(IC), .OUT_C(OC), .K(KK), .ACC_W(32), .SHIFT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .read_addr(read_addr),
    .read_data(rd1), .busy(busy1), .done(done1));

  // Reference model: memory images, a latency timeline and the expected output maps.
  logic signed [7:0] in_m [IN_D];
  logic signed [7:0] w_m [W_D];
  int b_m [OC];
  logic [7:0] exp0 [NOUT];
  logic [7:0] exp1 [NOUT];
  int t = -1;
  logic m_busy = 1'b0, m_done = 1'b0, m_rd_chk = 1'b0, chk_en = 1'b0;
  logic [7:0] m_rd0, m_rd1;

  function automatic logic [7:0] exp_val(input int a, input int sh);
    int oc, pix, ox, oy, acc, q;
    oc = a % OC; pix = a / OC; ox = pix % OW; oy = pix / OW;
    acc = b_m[oc];
    for (int ky = 0; ky < KK; ky++)
      for (int kx = 0; kx < KK; kx++)
        for (int ic = 0; ic < IC; ic++)
          acc += int'(in_m[((oy + ky) * IW + ox + kx) * IC + ic]) *
                 int'(w_m[((oc * KK + ky) * KK + kx) * IC + ic]);
    q = acc >>> sh;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
`ifdef CONV_RELU_EN
    if (q < 0) q = 0;
`endif
    return q[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    chk_en <= 1'b1;
    m_rd_chk <= m_done;
    m_rd0 <= (read_addr < 32'(NOUT)) ? exp0[read_addr[2:0]] : 8'h00;
    m_rd1 <= (read_addr < 32'(NOUT)) ? exp1[read_addr[2:0]] : 8'h00;
    if (reset) begin
      t <= -1; m_busy <= 1'b0; m_done <= 1'b0; m_rd_chk <= 1'b0;
    end else begin
      m_busy <= (t >= 0) && (t <= LAT - 2);
      m_done <= (t >= LAT - 1);
      if (load_en && (t < 0 || t >= LAT - 1)) begin
        case (load_sel)
          2'd0: if (load_addr < 32'(IN_D)) in_m[load_addr[4:0]] <= load_data[7:0];
          2'd1: if (load_addr < 32'(W_D)) w_m[load_addr[5:0]] <= load_data[7:0];
          2'd2: if (load_addr < 32'(OC)) b_m[load_addr[0]] <= $signed(load_data);
          default: ;
        endcase
      end
      if (start && (t < 0 || t >= LAT - 1)) t <= 0;
      else if (t >= 0 && t < LAT) t <= t + 1;
      if (t == LAT - 2)
        for (int i = 0; i < NOUT; i++) begin
          exp0[i] <= exp_val(i, 0);
          exp1[i] <= exp_val(i, 1);
        end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy0", 32'(busy0), 32'(m_busy));
      chk("busy1", 32'(busy1), 32'(m_busy));
      chk("done0", 32'(done0), 32'(m_done));
      chk("done1", 32'(done1), 32'(m_done));
      if (m_rd_chk) begin
        chk("rdata0", 32'(rd0), 32'(m_rd0));
        chk("rdata1", 32'(rd1), 32'(m_rd1));
      end
    end
  end

  task automatic load(input logic [1:0] s, input int a, input int d);
    @(negedge clk);
    load_en = 1'b1; load_sel = s; load_addr = 32'(a); load_data = 32'(d);
  endtask

  task automatic load_end();
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic fill(input logic [1:0] s, input int n, input int d);
    for (int i = 0; i < n; i++) load(s, i, d);
    load_end();
  endtask

  // inj: 0 plain run, 1 start+weight load at cycle 40, 2 reset at cycle 50.
  task automatic run(input int inj, output int nd, output int nb);
    int n;
    n = -1; nd = -1; nb = 0;
    @(negedge clk);
    start = 1'b1; load_en = 1'b0;
    while (n < 400 && nd < 0) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0; load_en = 1'b0; reset = 1'b0;
      if (busy0) nb++;
      if (inj == 2 && n == 51) begin
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_done", 32'(done0), 32'd0);
        nd = n;
      end else if (done0 && n > 0) begin
        nd = n;
      end else if (inj == 1 && n == 40) begin
        start = 1'b1; load_en = 1'b1; load_sel = 2'd1; load_addr = 32'd0; load_data = 32'd5;
      end else if (inj == 2 && n == 50) begin
        reset = 1'b1;
      end
    end
    if (nd < 0) begin
      checks++; failures++;
      $display("FAIL run_timeout: done not seen within %0d cycles", n);
    end
  endtask

  task automatic read_check(input int a, input logic [7:0] lit, input int which);
    @(negedge clk);
    read_addr = 32'(a);
    @(negedge clk);
    if (which == 0) chk("read0", 32'(rd0), 32'(lit));
    else chk("read1", 32'(rd1), 32'(lit));
    if (a >= 0 && a < NOUT) chk("model_pin", 32'(which == 0 ? exp0[a] : exp1[a]), 32'(lit));
  endtask

  initial begin
    int nd, nb;
    logic [7:0] s4 [NOUT];
    s4 = '{8'd5, 8'd0, 8'd6, 8'd0, 8'd9, 8'd0, 8'd10, 8'd0};
    reset = 1'b1; start = 1'b0; load_en = 1'b0; load_sel = 2'd0;
    load_addr = 32'd0; load_data = 32'd0; read_addr = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", 32'(rd0), 32'd0);
    chk("reset_busy0", 32'(busy0), 32'd0);
    chk("reset_done0", 32'(done0), 32'd0);
    reset = 1'b0;

    // Scenario 1: all ones, zero bias.
    fill(2'd0, IN_D, 1); fill(2'd1, W_D, 1); fill(2'd2, OC, 0);
    load(2'd3, 0, 99); load_end();
    run(0, nd, nb);
    chk("s1_done_cycle", 32'(nd), 32'd178);
    chk("s1_busy_cycles", 32'(nb), 32'd177);
    for (int a = 0; a < NOUT; a++) read_check(a, 8'h12, 0);
    read_check(8, 8'h00, 0);
    read_check(-1, 8'h00, 0);

    // Scenario 2: positive and negative saturation.
    fill(2'd0, IN_D, 127); fill(2'd1, W_D, 127);
    run(0, nd, nb);
    read_check(0, 8'h7F, 0); read_check(7, 8'h7F, 0);
    fill(2'd0, IN_D, -128);
    run(0, nd, nb);
    read_check(0, SAT_NEG, 0); read_check(5, SAT_NEG, 0);

    // Scenario 3: negative bias, floor shift on the SHIFT=1 instance.
    fill(2'd0, IN_D, 1); fill(2'd1, W_D, 1); fill(2'd2, OC, -20);
    run(0, nd, nb);
    read_check(0, MINUS1, 1); read_check(3, MINUS1, 1);

    // Scenario 4: ramp input through a single centre tap.
    fill(2'd2, OC, 0); fill(2'd1, W_D, 0);
    load(2'd1, 8, 1);
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++)
        for (int c = 0; c < IC; c++) load(2'd0, (y * IW + x) * IC + c, (c == 0) ? y * IW + x : 0);
    load_end();
    run(0, nd, nb);
    for (int a = 0; a < NOUT; a++) read_check(a, s4[a], 0);

    // Scenario 5: start and load during a run are ignored; out-of-range loads dropped.
    fill(2'd1, W_D, 1); fill(2'd0, IN_D, 1);
    load(2'd0, IN_D, 50); load(2'd1, W_D, 50); load(2'd2, OC, 50); load_end();
    run(1, nd, nb);
    chk("s5_done_cycle", 32'(nd), 32'd178);
    for (int a = 0; a < NOUT; a++) read_check(a, 8'h12, 0);

    // Scenario 6: reset mid-run, then a full recompute.
    run(2, nd, nb);
    run(0, nd, nb);
    chk("s6_done_cycle", 32'(nd), 32'd178);
    chk("s6_busy_cycles", 32'(nb), 32'd177);
    read_check(0, 8'h12, 0); read_check(6, 8'h12, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
